// File: rtl/grad_dir_scheduler_pkg.sv
// Shared widths, direction codes and FSM encoding for the gradient direction scheduler.
package grad_dir_scheduler_pkg;
  localparam int PIXEL_W = 12;
  localparam int GRAD_W  = PIXEL_W + 5;
  localparam int NUM_DIR = 4;
  localparam int NUM_TAP = 5;
  localparam int WIN_W   = NUM_TAP * PIXEL_W;

  localparam logic [1:0] DIR_N = 2'd0;
  localparam logic [1:0] DIR_E = 2'd1;
  localparam logic [1:0] DIR_S = 2'd2;
  localparam logic [1:0] DIR_W = 2'd3;

  typedef enum logic [1:0] {ST_IDLE, ST_EVAL, ST_DONE} state_e;

  typedef struct packed {
    logic [1:0]        dir;
    logic [GRAD_W-1:0] grad;
    logic              none;
  } result_t;

  // Pixel k (0 = e1) of a packed five-pixel window.
  function automatic logic [PIXEL_W-1:0] win_tap(input logic [WIN_W-1:0] w, input int k);
    return w[k*PIXEL_W +: PIXEL_W];
  endfunction
endpackage

// File: rtl/grad_dir_scheduler_if.sv
// Window-in / result-out handshakes plus the link to the shared gradient unit.
interface grad_dir_scheduler_if;
  import grad_dir_scheduler_pkg::*;

  logic               in_valid;
  logic               in_ready;
  logic [PIXEL_W-1:0] mean_in;
  logic [WIN_W-1:0]   win_n;
  logic [WIN_W-1:0]   win_e;
  logic [WIN_W-1:0]   win_s;
  logic [WIN_W-1:0]   win_w;
  logic [3:0]         dir_mask;
  logic [PIXEL_W-1:0] g_e1;
  logic [PIXEL_W-1:0] g_e2;
  logic [PIXEL_W-1:0] g_e3;
  logic [PIXEL_W-1:0] g_e4;
  logic [PIXEL_W-1:0] g_e5;
  logic [PIXEL_W-1:0] g_mean;
  logic [GRAD_W-1:0]  g_grad;
  logic               out_valid;
  logic               out_ready;
  logic [1:0]         dir_sel;
  logic [GRAD_W-1:0]  grad_min;
  logic               none_valid;

  modport master (
    output in_valid, mean_in, win_n, win_e, win_s, win_w, dir_mask, g_grad, out_ready,
    input  in_ready, g_e1, g_e2, g_e3, g_e4, g_e5, g_mean, out_valid, dir_sel, grad_min,
           none_valid
  );

  modport slave (
    input  in_valid, mean_in, win_n, win_e, win_s, win_w, dir_mask, g_grad, out_ready,
    output in_ready, g_e1, g_e2, g_e3, g_e4, g_e5, g_mean, out_valid, dir_sel, grad_min,
           none_valid
  );
endinterface

// File: rtl/grad_dir_scheduler_min_cmp.sv
// Registered running-minimum tracker; strict less-than keeps the earliest index on ties.
module grad_min_cmp
  import grad_dir_scheduler_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clear_i,
  input  logic              en_i,
  input  logic [GRAD_W-1:0] grad_i,
  input  logic [1:0]        idx_i,
  output logic [GRAD_W-1:0] min_o,
  output logic [1:0]        min_dir_o,
  output logic              found_o
);
  logic [GRAD_W-1:0] min_q, min_d;
  logic [1:0]        dir_q, dir_d;
  logic              found_q, found_d;

  always_comb begin
    min_d   = min_q;
    dir_d   = dir_q;
    found_d = found_q;
    if (clear_i) begin
      min_d   = '1;
      dir_d   = DIR_N;
      found_d = 1'b0;
    end else if (en_i && (!found_q || grad_i < min_q)) begin
      min_d   = grad_i;
      dir_d   = idx_i;
      found_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      min_q   <= '1;
      dir_q   <= DIR_N;
      found_q <= 1'b0;
    end else begin
      min_q   <= min_d;
      dir_q   <= dir_d;
      found_q <= found_d;
    end
  end

  assign min_o     = min_q;
  assign min_dir_o = dir_q;
  assign found_o   = found_q;
endmodule

// File: rtl/grad_dir_scheduler.sv
// Time-multiplexes one external weighted-gradient unit over the N/E/S/W windows
// and reports the direction with the smallest gradient.
module grad_dir_scheduler
  import grad_dir_scheduler_pkg::*;
(
  input  logic clk,
  input  logic rst,
  grad_dir_scheduler_if.slave bus
);
  state_e                          state_q, state_d;
  logic [1:0]                      idx_q, idx_d;
  logic [PIXEL_W-1:0]              mean_q;
  logic [NUM_DIR-1:0][WIN_W-1:0]   win_q;
  logic [NUM_DIR-1:0]              mask_q;
  logic                            accept;
  logic                            cmp_en;
  logic [GRAD_W-1:0]               cmp_min;
  logic [1:0]                      cmp_dir;
  logic                            cmp_found;
  logic [1:0]                      sel;
  logic [WIN_W-1:0]                cur_win;
  result_t                         res;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    accept  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.in_valid) begin
          accept  = 1'b1;
          idx_d   = 2'd0;
          state_d = ST_EVAL;
        end
      end
      ST_EVAL: begin
        idx_d = idx_q + 2'd1;
        if (idx_q == 2'd3) state_d = ST_DONE;
      end
      ST_DONE: begin
        // Release goes straight to IDLE; the next accept is a cycle later.
        if (bus.out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      idx_q   <= 2'd0;
      mean_q  <= '0;
      win_q   <= '0;
      mask_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      if (accept) begin
        mean_q   <= bus.mean_in;
        win_q[0] <= bus.win_n;
        win_q[1] <= bus.win_e;
        win_q[2] <= bus.win_s;
        win_q[3] <= bus.win_w;
        mask_q   <= bus.dir_mask;
      end
    end
  end

  assign cmp_en = (state_q == ST_EVAL) && mask_q[idx_q];

  grad_min_cmp u_cmp (
    .clk       (clk),
    .rst       (rst),
    .clear_i   (accept),
    .en_i      (cmp_en),
    .grad_i    (bus.g_grad),
    .idx_i     (idx_q),
    .min_o     (cmp_min),
    .min_dir_o (cmp_dir),
    .found_o   (cmp_found)
  );

  // Outside EVAL the unit sees the latched N window so its inputs stay deterministic.
  assign sel     = (state_q == ST_EVAL) ? idx_q : DIR_N;
  assign cur_win = win_q[sel];

  assign bus.g_e1   = win_tap(cur_win, 0);
  assign bus.g_e2   = win_tap(cur_win, 1);
  assign bus.g_e3   = win_tap(cur_win, 2);
  assign bus.g_e4   = win_tap(cur_win, 3);
  assign bus.g_e5   = win_tap(cur_win, 4);
  assign bus.g_mean = mean_q;

  always_comb begin
    res = '{dir: DIR_N, grad: '0, none: 1'b0};
    if (state_q == ST_DONE) begin
      if (cmp_found) begin
        res.dir  = cmp_dir;
        res.grad = cmp_min;
      end else begin
        res.grad = '1;
        res.none = 1'b1;
      end
    end
  end

  assign bus.in_ready   = (state_q == ST_IDLE);
  assign bus.out_valid  = (state_q == ST_DONE);
  assign bus.dir_sel    = res.dir;
  assign bus.grad_min   = res.grad;
  assign bus.none_valid = res.none;
endmodule
